// File: rtl/mod_swap_pkg.sv
// Shared types and defaults for the modulation page-swap controller.
package mod_swap_pkg;

  // Default width of modulation sample indices and cycle-length values.
  localparam int unsigned IdxWDefault = 15;

  // Swap controller states.
  typedef enum logic [1:0] {
    StIdle,
    StWaitWrap,
    StCommit
  } swap_state_e;

endpackage

// File: rtl/mod_page_swap_ctl.sv
// Page/cycle swap controller: accepts a swap request, optionally waits for the
// modulator to wrap past the active last index, then commits the shadowed page
// and cycle length in a single COMMIT cycle.
module mod_page_swap_ctl
  import mod_swap_pkg::*;
#(
  parameter int unsigned IDX_W = IdxWDefault
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             swap_req,
  input  logic             swap_page,
  input  logic             swap_mode,
  input  logic [IDX_W-1:0] new_cycle,
  input  logic [IDX_W-1:0] mod_idx,
  input  logic             idx_valid,
  input  logic             cancel,
  input  logic             clr_overrun,
  output logic             rd_page,
  output logic [IDX_W-1:0] cycle,
  output logic             busy,
  output logic             swap_done,
  output logic             overrun
);

  swap_state_e      state_q, state_d;
  logic             shd_page_q, shd_page_d;
  logic [IDX_W-1:0] shd_cycle_q, shd_cycle_d;
  logic             rd_page_q, rd_page_d;
  logic [IDX_W-1:0] cycle_q, cycle_d;
  logic             overrun_q, overrun_d;
  logic             wrap;

  // Unsigned >= so out-of-range indices also count as a wrap.
  assign wrap = idx_valid && (mod_idx >= cycle_q);

  // Next-state, shadow capture and commit decode.
  always_comb begin
    state_d     = state_q;
    shd_page_d  = shd_page_q;
    shd_cycle_d = shd_cycle_q;
    rd_page_d   = rd_page_q;
    cycle_d     = cycle_q;
    swap_done   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (swap_req) begin
          shd_page_d  = swap_page;
          shd_cycle_d = new_cycle;
          state_d     = swap_mode ? StWaitWrap : StCommit;
        end
      end
      StWaitWrap: begin
        // Cancel wins over a wrap seen on the same cycle.
        if (cancel) begin
          state_d = StIdle;
        end else if (wrap) begin
          state_d = StCommit;
        end
      end
      StCommit: begin
        rd_page_d = shd_page_q;
        cycle_d   = shd_cycle_q;
        swap_done = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Requests while busy (including the COMMIT exit edge) are dropped and flagged;
  // a set on the same cycle as a clear keeps the flag.
  always_comb begin
    overrun_d = overrun_q;
    if (swap_req && (state_q != StIdle)) begin
      overrun_d = 1'b1;
    end else if (clr_overrun) begin
      overrun_d = 1'b0;
    end
  end

  // State, shadow and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      shd_page_q  <= 1'b0;
      shd_cycle_q <= '0;
      rd_page_q   <= 1'b0;
      cycle_q     <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shd_page_q  <= shd_page_d;
      shd_cycle_q <= shd_cycle_d;
      rd_page_q   <= rd_page_d;
      cycle_q     <= cycle_d;
      overrun_q   <= overrun_d;
    end
  end

  assign busy    = (state_q != StIdle);
  assign rd_page = rd_page_q;
  assign cycle   = cycle_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_mod_page_swap_ctl.sv
// Self-checking bench for mod_page_swap_ctl: expected commits are queued when a
// request is driven and compared once the DUT commits.
module tb_mod_page_swap_ctl;

  localparam int unsigned W = 15;

  typedef struct packed {
    logic         page;
    logic [W-1:0] cyc;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         swap_req;
  logic         swap_page;
  logic         swap_mode;
  logic [W-1:0] new_cycle;
  logic [W-1:0] mod_idx;
  logic         idx_valid;
  logic         cancel;
  logic         clr_overrun;
  logic         rd_page;
  logic [W-1:0] cycle;
  logic         busy;
  logic         swap_done;
  logic         overrun;

  int   checks;
  int   errors;
  exp_t exp_q[$];
  exp_t e;

  mod_page_swap_ctl #(.IDX_W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .swap_req   (swap_req),
    .swap_page  (swap_page),
    .swap_mode  (swap_mode),
    .new_cycle  (new_cycle),
    .mod_idx    (mod_idx),
    .idx_valid  (idx_valid),
    .cancel     (cancel),
    .clr_overrun(clr_overrun),
    .rd_page    (rd_page),
    .cycle      (cycle),
    .busy       (busy),
    .swap_done  (swap_done),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a request; sampled by the next rising edge.
  task automatic drive_req(input logic page, input logic mode, input logic [W-1:0] cyc);
    swap_req  = 1'b1;
    swap_page = page;
    swap_mode = mode;
    new_cycle = cyc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (rd_page !== 1'b0 || cycle !== '0) begin
      errors++;
      $display("FAIL reset_page_cycle got page=%0b cycle=%0d want 0/0", rd_page, cycle);
    end
    checks++;
    if (busy !== 1'b0 || swap_done !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got busy=%0b done=%0b ovr=%0b want 0", busy, swap_done, overrun);
    end
  endtask

  task automatic test_immediate();
    exp_q.push_back('{page: 1'b1, cyc: 15'd3999});
    drive_req(1'b1, 1'b0, 15'd3999);
    @(negedge clk);  // edge k sampled the request
    swap_req = 1'b0;
    checks++;
    if (busy !== 1'b1 || swap_done !== 1'b1 || rd_page !== 1'b0) begin
      errors++;
      $display("FAIL imm_commit got busy=%0b done=%0b page=%0b want 1/1/0",
               busy, swap_done, rd_page);
    end
    @(negedge clk);  // edge k+1 committed; values stable for edge k+2
    checks++;
    if (busy !== 1'b0 || swap_done !== 1'b0) begin
      errors++;
      $display("FAIL imm_pulse_len got busy=%0b done=%0b want 0/0", busy, swap_done);
    end
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL imm_sb got empty queue want entry");
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (rd_page !== e.page || cycle !== e.cyc) begin
        errors++;
        $display("FAIL imm_result got page=%0b cycle=%0d want %0b/%0d", rd_page, cycle, e.page, e.cyc);
      end
    end
  endtask

  task automatic test_same_page();
    exp_q.push_back('{page: 1'b1, cyc: 15'd9});
    drive_req(1'b1, 1'b0, 15'd9);
    @(negedge clk);
    swap_req = 1'b0;
    checks++;
    if (swap_done !== 1'b1) begin
      errors++;
      $display("FAIL same_page_done got %0b want 1", swap_done);
    end
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (rd_page !== e.page || cycle !== e.cyc) begin
      errors++;
      $display("FAIL same_page_result got page=%0b cycle=%0d want %0b/%0d",
               rd_page, cycle, e.page, e.cyc);
    end
  endtask

  task automatic test_boundary();
    exp_q.push_back('{page: 1'b0, cyc: 15'd20});
    drive_req(1'b0, 1'b1, 15'd20);
    @(negedge clk);
    swap_req = 1'b0;
    for (int i = 0; i <= 9; i++) begin
      mod_idx   = W'(i);
      idx_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (i < 9) begin
        if (busy !== 1'b1 || swap_done !== 1'b0 || rd_page !== 1'b1) begin
          errors++;
          $display("FAIL bnd_wait idx=%0d got busy=%0b done=%0b page=%0b want 1/0/1",
                   i, busy, swap_done, rd_page);
        end
      end else begin
        if (swap_done !== 1'b1 || rd_page !== 1'b1) begin
          errors++;
          $display("FAIL bnd_commit got done=%0b page=%0b want 1/1", swap_done, rd_page);
        end
      end
    end
    idx_valid = 1'b0;
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (rd_page !== e.page || cycle !== e.cyc) begin
      errors++;
      $display("FAIL bnd_result got page=%0b cycle=%0d want %0b/%0d", rd_page, cycle, e.page, e.cyc);
    end
  endtask

  task automatic test_overrun();
    exp_q.push_back('{page: 1'b1, cyc: 15'd30});
    drive_req(1'b1, 1'b1, 15'd30);
    @(negedge clk);
    drive_req(1'b0, 1'b0, 15'd5);  // discarded
    @(negedge clk);
    swap_req = 1'b0;
    checks++;
    if (overrun !== 1'b1 || busy !== 1'b1 || swap_done !== 1'b0) begin
      errors++;
      $display("FAIL ovr_set got ovr=%0b busy=%0b done=%0b want 1/1/0", overrun, busy, swap_done);
    end
    mod_idx   = 15'd25;
    idx_valid = 1'b1;
    @(negedge clk);
    idx_valid = 1'b0;
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (rd_page !== e.page || cycle !== e.cyc) begin
      errors++;
      $display("FAIL ovr_first_wins got page=%0b cycle=%0d want %0b/%0d",
               rd_page, cycle, e.page, e.cyc);
    end
    exp_q.push_back('{page: 1'b0, cyc: 15'd7});
    drive_req(1'b0, 1'b1, 15'd7);
    @(negedge clk);
    drive_req(1'b1, 1'b0, 15'd99);
    clr_overrun = 1'b1;
    @(negedge clk);
    swap_req    = 1'b0;
    clr_overrun = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_set_beats_clr got %0b want 1", overrun);
    end
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_clear got %0b want 0", overrun);
    end
    mod_idx   = 15'd31;  // beyond the active last index of 30
    idx_valid = 1'b1;
    @(negedge clk);
    idx_valid = 1'b0;
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (rd_page !== e.page || cycle !== e.cyc) begin
      errors++;
      $display("FAIL ovr_oor_wrap got page=%0b cycle=%0d want %0b/%0d",
               rd_page, cycle, e.page, e.cyc);
    end
  endtask

  task automatic test_back_to_back();
    exp_q.push_back('{page: 1'b1, cyc: 15'd7});
    drive_req(1'b1, 1'b0, 15'd7);
    @(negedge clk);
    drive_req(1'b0, 1'b0, 15'd40);  // lands on the COMMIT exit edge
    @(negedge clk);
    swap_req = 1'b0;
    checks++;
    if (overrun !== 1'b1 || busy !== 1'b0 || swap_done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_flags got ovr=%0b busy=%0b done=%0b want 1/0/0", overrun, busy, swap_done);
    end
    e = exp_q.pop_front();
    checks++;
    if (rd_page !== e.page || cycle !== e.cyc) begin
      errors++;
      $display("FAIL b2b_result got page=%0b cycle=%0d want %0b/%0d", rd_page, cycle, e.page, e.cyc);
    end
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    checks++;
    if (busy !== 1'b0 || swap_done !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL b2b_dropped got busy=%0b done=%0b ovr=%0b want 0/0/0",
               busy, swap_done, overrun);
    end
  endtask

  task automatic test_cancel();
    drive_req(1'b0, 1'b1, 15'd50);  // never commits, nothing queued
    @(negedge clk);
    swap_req  = 1'b0;
    mod_idx   = 15'd7;
    idx_valid = 1'b1;
    cancel    = 1'b1;
    @(negedge clk);
    idx_valid = 1'b0;
    cancel    = 1'b0;
    checks++;
    if (busy !== 1'b0 || swap_done !== 1'b0) begin
      errors++;
      $display("FAIL cancel_idle got busy=%0b done=%0b want 0/0", busy, swap_done);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (swap_done !== 1'b0 || rd_page !== 1'b1 || cycle !== 15'd7) begin
        errors++;
        $display("FAIL cancel_hold cyc=%0d got done=%0b page=%0b cycle=%0d want 0/1/7",
                 i, swap_done, rd_page, cycle);
      end
    end
  endtask

  task automatic test_reset_mid();
    drive_req(1'b0, 1'b1, 15'd60);
    @(negedge clk);
    @(negedge clk);  // second request while waiting sets overrun
    swap_req = 1'b0;
    checks++;
    if (overrun !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre got ovr=%0b busy=%0b want 1/1", overrun, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (rd_page !== 1'b0 || cycle !== '0 || busy !== 1'b0 || swap_done !== 1'b0
        || overrun !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_async got page=%0b cycle=%0d busy=%0b done=%0b ovr=%0b want 0",
               rd_page, cycle, busy, swap_done, overrun);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_q.push_back('{page: 1'b1, cyc: 15'd100});
    drive_req(1'b1, 1'b0, 15'd100);
    @(negedge clk);
    swap_req = 1'b0;
    checks++;
    if (swap_done !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_accept got done=%0b want 1", swap_done);
    end
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (rd_page !== e.page || cycle !== e.cyc) begin
      errors++;
      $display("FAIL rst_mid_result got page=%0b cycle=%0d want %0b/%0d",
               rd_page, cycle, e.page, e.cyc);
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    swap_req    = 1'b0;
    swap_page   = 1'b0;
    swap_mode   = 1'b0;
    new_cycle   = '0;
    mod_idx     = '0;
    idx_valid   = 1'b0;
    cancel      = 1'b0;
    clr_overrun = 1'b0;
    test_reset();
    test_immediate();
    test_same_page();
    test_boundary();
    test_overrun();
    test_back_to_back();
    test_cancel();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d entries left want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
